// File: rtl/decoder_scan_seq_pkg.sv
// Shared types and constants for the decoder3_8 scan sequencer.
package decoder_scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CODE_MAX = 3'd7;

  // True when the current code is the final one of a single (non-wrapping) sweep.
  function automatic logic sweep_last(input logic [2:0] code, input logic cont);
    return (code == CODE_MAX) && !cont;
  endfunction

endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control/status bundle between the control logic (master) and the scan sequencer (slave).
interface decoder_scan_seq_if #(
  parameter int unsigned DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               E;
  logic [2:0]         In;
  logic               busy;
  logic               step;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, mode, dwell,
    input  E, In, busy, step, wrap, done
  );

  modport slave (
    input  start, stop, mode, dwell,
    output E, In, busy, step, wrap, done
  );
endinterface

// File: rtl/decoder_scan_seq_dwell_timer.sv
// Loadable down-counter that times how long each decoder code is held.
module dwell_timer #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_scan_seq.sv
// Sweeps decoder3_8 codes 0..7, holding each for dwell+1 cycles, in single or
// continuous mode; all outputs registered.
module decoder_scan_seq
  import decoder_scan_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clka,
  input  logic               rst,
  decoder_scan_seq_if.slave  bus
);

  state_t             state;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               e_q;
  logic [2:0]         code_q;
  logic               busy_q;
  logic               step_q;
  logic               wrap_q;
  logic               done_q;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_load_val;
  logic               tmr_en;
  logic               tmr_zero;

  // Timer is loaded from the live input on start, from the latched copy on reload.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = dwell_q;
    tmr_en       = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_load     = bus.start && !bus.stop;
        tmr_load_val = bus.dwell;
      end
      RUN: begin
        tmr_en   = !bus.stop;
        tmr_load = !bus.stop && tmr_zero && !sweep_last(code_q, mode_q);
      end
      default: ;
    endcase
  end

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clka     (clka),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      e_q     <= 1'b0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state   <= RUN;
            e_q     <= 1'b1;
            busy_q  <= 1'b1;
            code_q  <= '0;
            mode_q  <= bus.mode;
            dwell_q <= bus.dwell;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state  <= IDLE;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
            code_q <= '0;
          end else if (tmr_zero) begin
            if (code_q != CODE_MAX) begin
              code_q <= code_q + 3'd1;
              step_q <= 1'b1;
            end else if (mode_q) begin
              code_q <= '0;
              step_q <= 1'b1;
              wrap_q <= 1'b1;
            end else begin
              state  <= DONE;
              e_q    <= 1'b0;
              busy_q <= 1'b0;
              code_q <= '0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.E    = e_q;
  assign bus.In   = code_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed plus randomized bench for decoder_scan_seq against a cycle-count reference model.
module tb_decoder_scan_seq;

  localparam int unsigned DW = 4;

  logic clka = 1'b0;
  logic rst;

  decoder_scan_seq_if #(.DWELL_W(DW)) bus ();

  decoder_scan_seq #(.DWELL_W(DW)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  logic [7:0] dec_out;
  assign dec_out = bus.E ? (8'd1 << bus.In) : 8'd0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference: phase 0=idle 1=run 2=done; t = cycles elapsed since first E=1 cycle.
  int m_phase = 0;
  int m_t     = 0;
  int m_d     = 0;
  int m_m     = 0;

  function automatic int exp_in();
    return (m_phase == 1) ? ((m_t / (m_d + 1)) % 8) : 0;
  endfunction

  function automatic int exp_step();
    return (m_phase == 1 && m_t > 0 && (m_t % (m_d + 1)) == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input logic s, input logic p, input logic mo, input int dw);
    case (m_phase)
      0: if (s && !p) begin
           m_phase = 1; m_t = 0; m_d = dw; m_m = int'(mo);
         end
      1: if (p) m_phase = 0;
         else begin
           m_t++;
           if (m_m == 0 && m_t == 8 * (m_d + 1)) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] e_in, e_dec;
    e_in  = 8'(exp_in());
    e_dec = (m_phase == 1) ? (8'd1 << e_in[2:0]) : 8'd0;
    chk("E",    {7'd0, bus.E},    (m_phase == 1) ? 8'd1 : 8'd0);
    chk("In",   {5'd0, bus.In},   e_in);
    chk("busy", {7'd0, bus.busy}, (m_phase == 1) ? 8'd1 : 8'd0);
    chk("step", {7'd0, bus.step}, 8'(exp_step()));
    chk("wrap", {7'd0, bus.wrap}, (exp_step() == 1 && m_m == 1 && exp_in() == 0) ? 8'd1 : 8'd0);
    chk("done", {7'd0, bus.done}, (m_phase == 2) ? 8'd1 : 8'd0);
    chk("dec",  dec_out,          e_dec);
  endtask

  task automatic cycle(input logic s, input logic p, input logic mo, input int dw);
    bus.start = s;
    bus.stop  = p;
    bus.mode  = mo;
    bus.dwell = DW'(dw);
    @(posedge clka);
    model_step(s, p, mo, dw);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_d = 0; m_m = 0;
  endtask

  initial begin
    int e_cnt, s_cnt, done_at, n;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.dwell = '0;
    #1;
    check_all();
    #10 rst = 1'b0;

    // 1: dwell=0 single sweep
    cycle(1, 0, 0, 0);
    e_cnt = int'(bus.E); s_cnt = 0; done_at = 0;
    for (int i = 2; i <= 12; i++) begin
      cycle(0, 0, 0, 0);
      e_cnt += int'(bus.E);
      s_cnt += int'(bus.step);
      if (bus.done && done_at == 0) done_at = i;
    end
    chk("t1_e_cycles", 8'(e_cnt), 8'd8);
    chk("t1_steps",    8'(s_cnt), 8'd7);
    chk("t1_done_cyc", 8'(done_at), 8'd9);

    // 2: dwell=2 single sweep
    cycle(1, 0, 0, 2);
    e_cnt = 1; done_at = 0;
    for (int i = 2; i <= 30; i++) begin
      cycle(0, 0, 1, 7);
      e_cnt += int'(bus.E);
      if (bus.done && done_at == 0) done_at = i;
    end
    chk("t2_e_cycles", 8'(e_cnt), 8'd24);
    chk("t2_done_cyc", 8'(done_at), 8'd25);

    // 3: dwell=1 continuous, 3 sweeps, mode/dwell/start noise ignored, then stop
    cycle(1, 0, 1, 1);
    for (int i = 1; i <= 16; i++) cycle(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    chk("t3_wrap16", {7'd0, bus.wrap}, 8'd1);
    chk("t3_in0",    {5'd0, bus.In},   8'd0);
    for (int i = 17; i <= 50; i++) cycle(1'($urandom_range(0, 1)), 0, 0, int'($urandom_range(0, 15)));
    cycle(0, 1, 0, 0);
    chk("t3_stopE", {7'd0, bus.E}, 8'd0);
    cycle(0, 0, 0, 0);

    // 4: abort at In=3 with start held while busy
    cycle(1, 0, 0, 3);
    n = 0;
    while (!(m_phase == 1 && exp_in() == 3) && n < 200) begin cycle(1, 0, 0, 9); n++; end
    chk("t4_reach3", 8'(n < 200), 8'd1);
    cycle(0, 1, 0, 0);
    chk("t4_busy", {7'd0, bus.busy}, 8'd0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

    // 5: async reset mid-dwell at In=5
    cycle(1, 0, 0, 4);
    n = 0;
    while (!(m_phase == 1 && exp_in() == 5 && (m_t % 5) == 2) && n < 200) begin cycle(0, 0, 0, 0); n++; end
    chk("t5_reach5", 8'(n < 200), 8'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

    // 6: start+stop in IDLE, then start held through DONE
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
